// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit: compare-op encodings,
// 2-bit counter states and the saturating counter step.
package branch_predict_unit_pkg;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b010,
    BR_LTU = 3'b011,
    BR_GE  = 3'b100,
    BR_GEU = 3'b101
  } br_op_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // One training step of a 2-bit saturating counter.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluator; unused op codes never take.
module branch_compare
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] data_a,
  input  logic [XLEN-1:0] data_b,
  input  logic [2:0]      op,
  output logic            cmp
);

  always_comb begin
    cmp = 1'b0;
    case (op)
      BR_EQ:   cmp = (data_a == data_b);
      BR_NE:   cmp = (data_a != data_b);
      BR_LT:   cmp = ($signed(data_a) <  $signed(data_b));
      BR_LTU:  cmp = (data_a <  data_b);
      BR_GE:   cmp = ($signed(data_a) >= $signed(data_b));
      BR_GEU:  cmp = (data_a >= data_b);
      default: cmp = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// EX-stage branch resolution with a one-cycle registered result, a
// direct-mapped 2-bit counter BHT for IF lookup, and saturating statistics.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned BHT_ENTRIES = 16,
  parameter int unsigned STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   dataS1,
  input  logic [XLEN-1:0]   dataS2,
  input  logic [3:0]        branchop,
  input  logic              flush,
  output logic              res_valid,
  output logic              res_taken,
  output logic              res_mispredict,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0]  if_idx;
  logic [IDX_W-1:0]  ex_idx;
  logic              cmp;
  logic              resolve;
  logic              mispredict;
  logic              pc_unused;

  logic [1:0]        bht_q [BHT_ENTRIES];
  logic [1:0]        bht_d [BHT_ENTRIES];
  logic              res_valid_q, res_valid_d;
  logic              res_taken_q, res_taken_d;
  logic              res_mispredict_q, res_mispredict_d;
  logic [STAT_W-1:0] stat_branches_q, stat_branches_d;
  logic [STAT_W-1:0] stat_mispredicts_q, stat_mispredicts_d;

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .data_a (dataS1),
    .data_b (dataS2),
    .op     (branchop[2:0]),
    .cmp    (cmp)
  );

  assign if_idx    = if_pc[IDX_W+1:2];
  assign ex_idx    = ex_pc[IDX_W+1:2];
  // Byte-offset and upper PC bits do not participate in indexing.
  assign pc_unused = ^{if_pc, ex_pc};

  assign if_pred_taken = bht_q[if_idx][1];

  assign resolve    = ex_valid & branchop[3] & ~flush;
  assign mispredict = cmp != ex_pred_taken;

  always_comb begin
    bht_d              = bht_q;
    res_valid_d        = resolve;
    res_taken_d        = resolve & cmp;
    res_mispredict_d   = resolve & mispredict;
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (resolve) begin
      bht_d[ex_idx] = ctr_update(bht_q[ex_idx], cmp);
      if (stat_branches_q != {STAT_W{1'b1}})
        stat_branches_d = stat_branches_q + STAT_W'(1);
      if (mispredict && (stat_mispredicts_q != {STAT_W{1'b1}}))
        stat_mispredicts_d = stat_mispredicts_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= CTR_WNT;
      res_valid_q        <= 1'b0;
      res_taken_q        <= 1'b0;
      res_mispredict_q   <= 1'b0;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      bht_q              <= bht_d;
      res_valid_q        <= res_valid_d;
      res_taken_q        <= res_taken_d;
      res_mispredict_q   <= res_mispredict_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign res_valid        = res_valid_q;
  assign res_taken        = res_taken_q;
  assign res_mispredict   = res_mispredict_q;
  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: driver pushes expectations from a
// behavioural model, a monitor pops and compares them against the DUT.
module tb_branch_predict_unit;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PC_W     = 32;
  localparam int unsigned BHT_N    = 16;
  localparam int unsigned STAT_W   = 8;
  localparam int          STAT_MAX = (1 << STAT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic [PC_W-1:0]   if_pc;
  logic              if_pred_taken;
  logic              ex_valid;
  logic [PC_W-1:0]   ex_pc;
  logic              ex_pred_taken;
  logic [XLEN-1:0]   dataS1;
  logic [XLEN-1:0]   dataS2;
  logic [3:0]        branchop;
  logic              flush;
  logic              res_valid;
  logic              res_taken;
  logic              res_mispredict;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  branch_predict_unit #(
    .XLEN(XLEN), .PC_W(PC_W), .BHT_ENTRIES(BHT_N), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .dataS1(dataS1), .dataS2(dataS2), .branchop(branchop), .flush(flush),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v;
    logic t;
    logic m;
    int   br;
    int   mis;
  } res_t;

  res_t res_q[$];
  bit   pred_q[$];

  int bht [BHT_N];
  int m_br;
  int m_mis;
  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit model_cmp(input logic [2:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    case (op)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return $signed(a) < $signed(b);
      3'd3:    return a < b;
      3'd4:    return $signed(a) >= $signed(b);
      3'd5:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(input logic [PC_W-1:0] pc);
    return int'((pc / 4) % BHT_N);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(BHT_N); i++) bht[i] = 1;
    m_br  = 0;
    m_mis = 0;
  endtask

  // Apply one cycle of stimulus at the falling edge and record expectations.
  task automatic issue(input logic v, input logic [PC_W-1:0] pc, input logic pred,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [3:0] bop, input logic fl, input logic [PC_W-1:0] ipc);
    res_t r;
    bit   c;
    bit   resolve;
    @(negedge clk);
    ex_valid = v; ex_pc = pc; ex_pred_taken = pred; dataS1 = a; dataS2 = b;
    branchop = bop; flush = fl; if_pc = ipc;
    pred_q.push_back(bht[idx_of(ipc)] >= 2);
    resolve = v && bop[3] && !fl;
    c       = model_cmp(bop[2:0], a, b);
    if (resolve) begin
      if (c) bht[idx_of(pc)] = (bht[idx_of(pc)] == 3) ? 3 : bht[idx_of(pc)] + 1;
      else   bht[idx_of(pc)] = (bht[idx_of(pc)] == 0) ? 0 : bht[idx_of(pc)] - 1;
      if (m_br < STAT_MAX) m_br++;
      if (c != pred && m_mis < STAT_MAX) m_mis++;
    end
    r.v = resolve; r.t = resolve && c; r.m = resolve && (c != pred);
    r.br = m_br; r.mis = m_mis;
    res_q.push_back(r);
  endtask

  task automatic idle(input logic [PC_W-1:0] ipc);
    issue(1'b0, '0, 1'b0, '0, '0, 4'b0000, 1'b0, ipc);
  endtask

  // Monitor: prediction checked mid-cycle, registered result after the edge.
  initial begin
    bit   ep;
    res_t er;
    forever begin
      @(negedge clk);
      #1;
      if (pred_q.size() > 0) begin
        ep = pred_q.pop_front();
        chk("if_pred_taken", 32'(if_pred_taken), 32'(ep));
      end
      @(posedge clk);
      #1;
      if (res_q.size() > 0) begin
        er = res_q.pop_front();
        chk("res_valid", 32'(res_valid), 32'(er.v));
        chk("res_taken", 32'(res_taken), 32'(er.t));
        chk("res_mispredict", 32'(res_mispredict), 32'(er.m));
        chk("stat_branches", 32'(stat_branches), 32'(er.br));
        chk("stat_mispredicts", 32'(stat_mispredicts), 32'(er.mis));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] a, b;
    logic [3:0]      bop;
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] neg1;
    bit              c;
    neg1 = '1;
    model_reset();
    rst_n = 1'b0; ex_valid = 0; ex_pc = '0; ex_pred_taken = 0; dataS1 = '0;
    dataS2 = '0; branchop = '0; flush = 0; if_pc = 32'h40;
    #12;
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_stat_branches", 32'(stat_branches), 32'd0);
    chk("reset_pred", 32'(if_pred_taken), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    idle(32'h40);
    issue(1, 32'h40, 0, 32'd5, 32'd5, 4'b1000, 0, 32'h40);
    idle(32'h40);
    // Signedness with -1 against 1.
    issue(1, 32'h80, 0, neg1, 32'd1, 4'b1010, 0, 32'h80);
    issue(1, 32'h80, 0, neg1, 32'd1, 4'b1011, 0, 32'h80);
    issue(1, 32'h80, 0, neg1, 32'd1, 4'b1100, 0, 32'h80);
    issue(1, 32'h80, 0, neg1, 32'd1, 4'b1101, 0, 32'h80);
    // Saturation walk at 0x44: four taken then one not-taken.
    for (int i = 0; i < 4; i++) issue(1, 32'h44, 1, 32'd7, 32'd7, 4'b1000, 0, 32'h44);
    issue(1, 32'h44, 1, 32'd7, 32'd8, 4'b1000, 0, 32'h44);
    idle(32'h44);
    // Flushed taken BNE and a non-branch op must leave no trace.
    issue(1, 32'h48, 0, 32'd1, 32'd2, 4'b1001, 1, 32'h48);
    issue(1, 32'h48, 0, 32'd1, 32'd2, 4'b0001, 0, 32'h48);
    issue(1, 32'h48, 0, 32'd1, 32'd2, 4'b1110, 0, 32'h48);
    idle(32'h48);

    for (int n = 0; n < 400; n++) begin
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 3) == 0) ? neg1 : $urandom);
      bop = {($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7))};
      pc  = PC_W'({$urandom_range(0, 63), 2'b00});
      issue(($urandom_range(0, 9) != 0), pc, 1'($urandom_range(0, 1)), a, b, bop,
            ($urandom_range(0, 9) == 0), PC_W'({$urandom_range(0, 63), 2'b00}));
    end
    // Every branch mispredicts so both statistics reach saturation.
    for (int n = 0; n < 300; n++) begin
      a   = $urandom;
      b   = ($urandom_range(0, 2) == 0) ? a : $urandom;
      bop = {1'b1, 3'($urandom_range(0, 7))};
      c   = model_cmp(bop[2:0], a, b);
      pc  = PC_W'({$urandom_range(0, 63), 2'b00});
      issue(1, pc, !c, a, b, bop, 0, pc);
    end

    // Mid-stream asynchronous reset with a result on the outputs.
    issue(1, 32'h40, 1, 32'd3, 32'd3, 4'b1000, 0, 32'h40);
    issue(1, 32'h40, 0, 32'd3, 32'd3, 4'b1000, 0, 32'h40);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_res_valid", 32'(res_valid), 32'd0);
    chk("async_res_taken", 32'(res_taken), 32'd0);
    chk("async_res_mispredict", 32'(res_mispredict), 32'd0);
    chk("async_stat_branches", 32'(stat_branches), 32'd0);
    chk("async_stat_mispredicts", 32'(stat_mispredicts), 32'd0);
    chk("async_pred", 32'(if_pred_taken), 32'd0);
    model_reset();
    @(negedge clk);
    ex_valid = 1'b0;
    rst_n    = 1'b1;
    idle(32'h40);
    issue(1, 32'h40, 1, 32'd9, 32'd4, 4'b1101, 0, 32'h40);
    idle(32'h40);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(res_q.size() + pred_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
